// File: rtl/serial_addsub_if.sv
// Handshake and data bundle for the bit-serial adder/subtractor.
// The slave side is the arithmetic unit; the master side issues operations.
interface serial_addsub_if #(
    parameter int N = 8
);
    logic         start;
    logic         sub;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         busy;
    logic         done;
    logic [N-1:0] result;
    logic         carry_out;
    logic         overflow;
    logic         sout;
    logic         sout_valid;

    modport master (
        output start, sub, a, b,
        input  busy, done, result, carry_out, overflow, sout, sout_valid
    );

    modport slave (
        input  start, sub, a, b,
        output busy, done, result, carry_out, overflow, sout, sout_valid
    );
endinterface

// File: rtl/serial_addsub.sv
// Bit-serial N-bit adder/subtractor: one result bit per clock, LSB first,
// with start/busy/done handshake, carry and signed-overflow flags.
module serial_addsub #(
    parameter int N = 8
) (
    input  logic              clk,
    input  logic              reset,
    serial_addsub_if.slave    bus
);
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [N-1:0]  a_q, a_d;
    logic [N-1:0]  b_q, b_d;
    logic [N-1:0]  r_q, r_d;
    logic          c_q, c_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          cout_q, cout_d;
    logic          ovf_q, ovf_d;

    logic          sum_bit;
    logic          carry_next;

    assign sum_bit    = a_q[0] ^ b_q[0] ^ c_q;
    assign carry_next = (a_q[0] & b_q[0]) | (a_q[0] & c_q) | (b_q[0] & c_q);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            r_q     <= '0;
            c_q     <= 1'b0;
            cnt_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            r_q     <= r_d;
            c_q     <= c_d;
            cnt_q   <= cnt_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        r_d     = r_q;
        c_d     = c_q;
        cnt_d   = cnt_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;

        unique case (state_q)
            S_IDLE, S_DONE: begin
                if (bus.start) begin
                    // Subtraction is a + ~b + 1: invert B and seed the carry with 1.
                    a_d     = bus.a;
                    b_d     = bus.sub ? ~bus.b : bus.b;
                    c_d     = bus.sub;
                    cnt_d   = '0;
                    state_d = S_RUN;
                end else if (state_q == S_DONE) begin
                    state_d = S_IDLE;
                end
            end
            S_RUN: begin
                r_d   = {sum_bit, r_q[N-1:1]};
                a_d   = {1'b0, a_q[N-1:1]};
                b_d   = {1'b0, b_q[N-1:1]};
                c_d   = carry_next;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == LAST) begin
                    // Signed overflow: carry into the MSB differs from carry out of it.
                    cout_d  = carry_next;
                    ovf_d   = c_q ^ carry_next;
                    state_d = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign bus.busy       = (state_q == S_RUN);
    assign bus.done       = (state_q == S_DONE);
    assign bus.result     = r_q;
    assign bus.carry_out  = cout_q;
    assign bus.overflow   = ovf_q;
    assign bus.sout       = sum_bit;
    assign bus.sout_valid = (state_q == S_RUN);
endmodule

// File: tb/tb_serial_addsub.sv
// Directed bench for serial_addsub at N=8, N=16 and N=2 with hand-computed results.
module tb_serial_addsub;
    logic clk;
    logic reset;
    int   vec_count;
    int   miscompares;

    serial_addsub_if #(.N(8))  i8 ();
    serial_addsub_if #(.N(16)) i16 ();
    serial_addsub_if #(.N(2))  i2 ();

    serial_addsub #(.N(8))  u8  (.clk(clk), .reset(reset), .bus(i8.slave));
    serial_addsub #(.N(16)) u16 (.clk(clk), .reset(reset), .bus(i16.slave));
    serial_addsub #(.N(2))  u2  (.clk(clk), .reset(reset), .bus(i2.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Issue one op on the 8-bit unit and collect result, flags, latency and sout stream.
    task automatic op8(input logic [7:0] av, input logic [7:0] bv, input logic sb,
                       output logic [7:0] r, output logic co, output logic ov,
                       output int lat, output logic [7:0] bits, output int nbits);
        @(posedge clk); #1;
        i8.start = 1'b1; i8.a = av; i8.b = bv; i8.sub = sb;
        @(posedge clk); #1;
        i8.start = 1'b0;
        lat = 1; nbits = 0; bits = '0;
        while (!i8.done && lat < 40) begin
            if (i8.sout_valid) begin
                if (nbits < 8) bits[nbits] = i8.sout;
                nbits++;
            end
            @(posedge clk); #1;
            lat++;
        end
        r = i8.result; co = i8.carry_out; ov = i8.overflow;
    endtask

    task automatic test_reset();
        vec_count++;
        if ({i8.busy, i8.done, i8.sout_valid, i8.sout, i8.carry_out, i8.overflow} !== 6'b0 ||
            i8.result !== 8'h00) begin
            miscompares++;
            $display("FAIL reset_state: busy=%b done=%b sv=%b sout=%b co=%b ov=%b result=%h, required all 0",
                     i8.busy, i8.done, i8.sout_valid, i8.sout, i8.carry_out, i8.overflow, i8.result);
        end
        $display("reset: result=%h busy=%b done=%b", i8.result, i8.busy, i8.done);
    endtask

    task automatic test_basic_add();
        logic [7:0] r, bits; logic co, ov; int lat, nb;
        op8(8'h4A, 8'h33, 1'b0, r, co, ov, lat, bits, nb);
        $display("add 4A+33: result=%h co=%b ov=%b lat=%0d sout=%b", r, co, ov, lat, bits);
        vec_count++;
        if (r !== 8'h7D || co !== 1'b0 || ov !== 1'b0) begin
            miscompares++;
            $display("FAIL add_4A_33: got %h/%b/%b, required 7d/0/0", r, co, ov);
        end
        vec_count++;
        if (lat !== 9) begin
            miscompares++;
            $display("FAIL add_latency: got %0d edges, required 9", lat);
        end
        vec_count++;
        if (bits !== 8'b0111_1101 || nb !== 8) begin
            miscompares++;
            $display("FAIL sout_stream: got bits %b (%0d valid), required 01111101 (8 valid)", bits, nb);
        end
    endtask

    task automatic test_flags();
        logic [7:0] r, bits; logic co, ov; int lat, nb;
        op8(8'hFF, 8'h01, 1'b0, r, co, ov, lat, bits, nb);
        $display("add FF+01: result=%h co=%b ov=%b", r, co, ov);
        vec_count++;
        if (r !== 8'h00 || co !== 1'b1 || ov !== 1'b0) begin
            miscompares++;
            $display("FAIL add_FF_01: got %h/%b/%b, required 00/1/0", r, co, ov);
        end
        op8(8'h7F, 8'h01, 1'b0, r, co, ov, lat, bits, nb);
        $display("add 7F+01: result=%h co=%b ov=%b", r, co, ov);
        vec_count++;
        if (r !== 8'h80 || co !== 1'b0 || ov !== 1'b1) begin
            miscompares++;
            $display("FAIL add_7F_01: got %h/%b/%b, required 80/0/1", r, co, ov);
        end
    endtask

    task automatic test_sub();
        logic [7:0] r, bits; logic co, ov; int lat, nb;
        op8(8'h33, 8'h4A, 1'b1, r, co, ov, lat, bits, nb);
        $display("sub 33-4A: result=%h co=%b ov=%b", r, co, ov);
        vec_count++;
        if (r !== 8'hE9 || co !== 1'b0 || ov !== 1'b0) begin
            miscompares++;
            $display("FAIL sub_33_4A: got %h/%b/%b, required e9/0/0", r, co, ov);
        end
        op8(8'h80, 8'h01, 1'b1, r, co, ov, lat, bits, nb);
        $display("sub 80-01: result=%h co=%b ov=%b", r, co, ov);
        vec_count++;
        if (r !== 8'h7F || co !== 1'b1 || ov !== 1'b1) begin
            miscompares++;
            $display("FAIL sub_80_01: got %h/%b/%b, required 7f/1/1", r, co, ov);
        end
    endtask

    task automatic test_ignore_start();
        int lat;
        @(posedge clk); #1;
        i8.start = 1'b1; i8.a = 8'h4A; i8.b = 8'h33; i8.sub = 1'b0;
        @(posedge clk); #1;
        i8.start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        i8.start = 1'b1; i8.a = 8'h11; i8.b = 8'h11; i8.sub = 1'b1;
        @(posedge clk); #1;
        i8.start = 1'b0;
        lat = 0;
        while (!i8.done && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        $display("ignore start: result=%h co=%b", i8.result, i8.carry_out);
        vec_count++;
        if (i8.result !== 8'h7D || i8.carry_out !== 1'b0 || !i8.done) begin
            miscompares++;
            $display("FAIL ignore_start: got result=%h co=%b done=%b, required 7d/0/1",
                     i8.result, i8.carry_out, i8.done);
        end
        @(posedge clk); #1;
        vec_count++;
        if (i8.done !== 1'b0 || i8.busy !== 1'b0) begin
            miscompares++;
            $display("FAIL done_to_idle: got done=%b busy=%b, required 0/0", i8.done, i8.busy);
        end
    endtask

    task automatic test_back_to_back();
        int t, first, second;
        logic busy_after;
        @(posedge clk); #1;
        i8.start = 1'b1; i8.a = 8'h4A; i8.b = 8'h33; i8.sub = 1'b0;
        @(posedge clk); #1;
        t = 1; first = -1; second = -1; busy_after = 1'b0;
        while (second < 0 && t < 40) begin
            if (i8.done) begin
                if (first < 0) first = t;
                else second = t;
            end
            if (second < 0) begin
                @(posedge clk); #1;
                t++;
                if (first == t - 1) busy_after = i8.busy;
            end
        end
        i8.start = 1'b0;
        $display("back-to-back: done at %0d and %0d, result=%h", first, second, i8.result);
        vec_count++;
        if (first !== 9 || second - first !== 9) begin
            miscompares++;
            $display("FAIL b2b_period: got done at %0d,%0d, required 9,18", first, second);
        end
        vec_count++;
        if (busy_after !== 1'b1 || i8.result !== 8'h7D) begin
            miscompares++;
            $display("FAIL b2b_restart: got busy_after_done=%b result=%h, required 1/7d",
                     busy_after, i8.result);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_async_reset();
        logic [7:0] r, bits; logic co, ov; int lat, nb;
        op8(8'h7F, 8'h01, 1'b0, r, co, ov, lat, bits, nb);
        @(posedge clk); #1;
        i8.start = 1'b1; i8.a = 8'h4A; i8.b = 8'h33; i8.sub = 1'b0;
        @(posedge clk); #1;
        i8.start = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        #1 reset = 1'b0;
        #1;
        $display("async reset mid-run: busy=%b result=%h ov=%b", i8.busy, i8.result, i8.overflow);
        vec_count++;
        if ({i8.busy, i8.done, i8.sout_valid, i8.carry_out, i8.overflow} !== 5'b0 ||
            i8.result !== 8'h00) begin
            miscompares++;
            $display("FAIL async_reset: busy=%b done=%b sv=%b co=%b ov=%b result=%h, required all 0",
                     i8.busy, i8.done, i8.sout_valid, i8.carry_out, i8.overflow, i8.result);
        end
        @(posedge clk); #2;
        reset = 1'b1;
        op8(8'h01, 8'h02, 1'b0, r, co, ov, lat, bits, nb);
        $display("after reset add 01+02: result=%h co=%b ov=%b", r, co, ov);
        vec_count++;
        if (r !== 8'h03 || co !== 1'b0 || ov !== 1'b0 || lat !== 9) begin
            miscompares++;
            $display("FAIL post_reset_add: got %h/%b/%b lat %0d, required 03/0/0 lat 9", r, co, ov, lat);
        end
    endtask

    task automatic test_width16();
        int lat;
        @(posedge clk); #1;
        i16.start = 1'b1; i16.a = 16'hFFFF; i16.b = 16'h0001; i16.sub = 1'b0;
        @(posedge clk); #1;
        i16.start = 1'b0;
        lat = 1;
        while (!i16.done && lat < 60) begin
            @(posedge clk); #1;
            lat++;
        end
        $display("N=16 add FFFF+0001: result=%h co=%b lat=%0d", i16.result, i16.carry_out, lat);
        vec_count++;
        if (i16.result !== 16'h0000 || i16.carry_out !== 1'b1 || lat !== 17) begin
            miscompares++;
            $display("FAIL n16_add: got %h/%b lat %0d, required 0000/1 lat 17",
                     i16.result, i16.carry_out, lat);
        end
    endtask

    task automatic test_width2();
        int lat;
        @(posedge clk); #1;
        i2.start = 1'b1; i2.a = 2'b01; i2.b = 2'b10; i2.sub = 1'b1;
        @(posedge clk); #1;
        i2.start = 1'b0;
        lat = 1;
        while (!i2.done && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        $display("N=2 sub 01-10: result=%b co=%b ov=%b lat=%0d", i2.result, i2.carry_out, i2.overflow, lat);
        vec_count++;
        if (i2.result !== 2'b11 || i2.carry_out !== 1'b0 || i2.overflow !== 1'b1 || lat !== 3) begin
            miscompares++;
            $display("FAIL n2_sub: got %b/%b/%b lat %0d, required 11/0/1 lat 3",
                     i2.result, i2.carry_out, i2.overflow, lat);
        end
    endtask

    initial begin
        vec_count = 0;
        miscompares = 0;
        reset = 1'b0;
        i8.start = 1'b0;  i8.sub = 1'b0;  i8.a = '0;  i8.b = '0;
        i16.start = 1'b0; i16.sub = 1'b0; i16.a = '0; i16.b = '0;
        i2.start = 1'b0;  i2.sub = 1'b0;  i2.a = '0;  i2.b = '0;
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        reset = 1'b1;
        test_basic_add();
        test_flags();
        test_sub();
        test_ignore_start();
        test_back_to_back();
        test_async_reset();
        test_width16();
        test_width2();
        $display("== %0d vectors applied, %0d miscompares ==", vec_count, miscompares);
        $finish;
    end
endmodule
